// File: rtl/button_debouncer_multi.sv
// Multi-channel push-button conditioner: per channel a synchroniser, a
// consecutive-sample debouncer, a clean level, single-cycle press/release
// strobes and an optional hold-to-repeat strobe.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   i_button   raw asynchronous pin levels (polarity per INVERT)
//   o_level    debounced level, 1 = pressed
//   o_press    1-cycle strobe on an accepted 0->1
//   o_release  1-cycle strobe on an accepted 1->0
//   o_repeat   1-cycle auto-repeat strobe while held
module button_debouncer_multi #(
    parameter int unsigned          CHANNELS        = 4,
    parameter int unsigned          DEBOUNCE_CYCLES = 4,
    parameter int unsigned          SYNC_STAGES     = 2,
    parameter logic [CHANNELS-1:0]  INVERT          = '0,
    parameter bit                   REPEAT_EN       = 1'b1,
    parameter int unsigned          HOLD_CYCLES     = 10,
    parameter int unsigned          REPEAT_CYCLES   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] i_button,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release,
    output logic [CHANNELS-1:0] o_repeat
);

    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HC_W     = $clog2(HOLD_MAX + 1);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [DB_W-1:0]        r_db_cnt;
        logic                   r_level;
        logic                   r_press;
        logic                   r_release;
        logic                   w_s;
        logic                   w_diff;
        logic                   w_accept;

        // Polarity fix-up ahead of the synchroniser so everything after sees 1 = pressed
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], i_button[gi] ^ INVERT[gi]};
            end
        end

        assign w_s      = r_sync[SYNC_STAGES-1];
        assign w_diff   = w_s ^ r_level;
        // The count holds the number of prior differing samples, so this is the Nth one
        assign w_accept = w_diff && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

        // Debounce counter, level and strobes; any matching sample restarts the count
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_db_cnt  <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                if (!w_diff) begin
                    r_db_cnt <= '0;
                end else if (w_accept) begin
                    r_db_cnt  <= '0;
                    r_level   <= ~r_level;
                    r_press   <= ~r_level;
                    r_release <= r_level;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end
        end

        assign o_level[gi]   = r_level;
        assign o_press[gi]   = r_press;
        assign o_release[gi] = r_release;

        if (REPEAT_EN) begin : g_rpt
            typedef enum logic [1:0] {
                ST_IDLE = 2'd0,
                ST_HOLD = 2'd1,
                ST_RPT  = 2'd2
            } hold_state_t;

            hold_state_t     r_state;
            hold_state_t     w_state_nxt;
            logic [HC_W-1:0] r_hold_cnt;
            logic [HC_W-1:0] w_hold_cnt_nxt;
            logic            r_repeat;
            logic            w_press_acc;
            logic            w_rel_acc;
            logic            w_rpt_fire;

            assign w_press_acc = w_accept & ~r_level;
            assign w_rel_acc   = w_accept &  r_level;

            // State register; the repeat strobe is registered alongside it
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state    <= ST_IDLE;
                    r_hold_cnt <= '0;
                    r_repeat   <= 1'b0;
                end else begin
                    r_state    <= w_state_nxt;
                    r_hold_cnt <= w_hold_cnt_nxt;
                    r_repeat   <= w_rpt_fire;
                end
            end

            // Fire on the last count of the current interval, but never on the release cycle
            always_comb begin
                w_rpt_fire = 1'b0;
                unique case (r_state)
                    ST_HOLD: w_rpt_fire = (r_hold_cnt == HC_W'(HOLD_CYCLES - 1));
                    ST_RPT:  w_rpt_fire = (r_hold_cnt == HC_W'(REPEAT_CYCLES - 1));
                    default: w_rpt_fire = 1'b0;
                endcase
                if (w_rel_acc) begin
                    w_rpt_fire = 1'b0;
                end
            end

            // Next-state and hold counter
            always_comb begin
                w_state_nxt    = r_state;
                w_hold_cnt_nxt = r_hold_cnt;
                unique case (r_state)
                    ST_IDLE: begin
                        w_hold_cnt_nxt = '0;
                        if (w_press_acc) begin
                            w_state_nxt = ST_HOLD;
                        end
                    end
                    ST_HOLD, ST_RPT: begin
                        if (w_rel_acc) begin
                            w_state_nxt    = ST_IDLE;
                            w_hold_cnt_nxt = '0;
                        end else if (w_rpt_fire) begin
                            w_state_nxt    = ST_RPT;
                            w_hold_cnt_nxt = '0;
                        end else begin
                            w_hold_cnt_nxt = r_hold_cnt + HC_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt    = ST_IDLE;
                        w_hold_cnt_nxt = '0;
                    end
                endcase
            end

            assign o_repeat[gi] = r_repeat;
        end else begin : g_no_rpt
            assign o_repeat[gi] = 1'b0;
        end
    end

endmodule

// File: tb/tb_button_debouncer_multi.sv
// Directed bench for button_debouncer_multi (CHANNELS=4, INVERT=4'b0101).
// The bench drives a logical "pressed" vector; pins are that vector XOR INVERT.
// Each scenario records, per channel, the cycle at which press and release
// strobes are due; every cycle all four outputs of every channel are checked.
module tb_button_debouncer_multi;

    localparam int unsigned  CH    = 4;
    localparam logic [CH-1:0] INV  = 4'b0101;
    localparam int           LAT   = 6;   // SYNC_STAGES + DEBOUNCE_CYCLES
    localparam int           HOLD  = 10;
    localparam int           RPT   = 3;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] btn;
    logic [CH-1:0] i_button;
    logic [CH-1:0] o_level;
    logic [CH-1:0] o_press;
    logic [CH-1:0] o_release;
    logic [CH-1:0] o_repeat;

    int n_checks;
    int n_errors;
    int cyc;
    int pc [CH];
    int rc [CH];

    assign i_button = btn ^ INV;

    button_debouncer_multi #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .INVERT          (INV),
        .REPEAT_EN       (1'b1),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (RPT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_button  (i_button),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_repeat  (o_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic exp_level(int ch);
        if (pc[ch] < 0 || cyc < pc[ch]) return 1'b0;
        if (rc[ch] >= 0 && cyc >= rc[ch]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_repeat(int ch);
        int d;
        if (pc[ch] < 0) return 1'b0;
        if (rc[ch] >= 0 && cyc >= rc[ch]) return 1'b0;
        d = cyc - pc[ch];
        if (d < HOLD) return 1'b0;
        return ((d - HOLD) % RPT) == 0;
    endfunction

    // Advance one clock, then compare every output bit with the scenario timeline
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int ch = 0; ch < CH; ch++) begin
                check_eq($sformatf("level%0d", ch),   32'(o_level[ch]),   32'(exp_level(ch)));
                check_eq($sformatf("press%0d", ch),   32'(o_press[ch]),   32'(pc[ch] >= 0 && cyc == pc[ch]));
                check_eq($sformatf("release%0d", ch), 32'(o_release[ch]), 32'(rc[ch] >= 0 && cyc == rc[ch]));
                check_eq($sformatf("repeat%0d", ch),  32'(o_repeat[ch]),  32'(exp_repeat(ch)));
            end
        end
    endtask

    task automatic drive(input int ch, input logic v);
        btn[ch] = v;
        if (v) begin
            pc[ch] = cyc + LAT;
            rc[ch] = -1;
        end else begin
            rc[ch] = cyc + LAT;
        end
    endtask

    initial begin
        logic [5:0] bounce;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        for (int ch = 0; ch < CH; ch++) begin
            pc[ch] = -1;
            rc[ch] = -1;
        end
        btn   = '0;
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_level",   32'(o_level),   32'h0);
        check_eq("rst_press",   32'(o_press),   32'h0);
        check_eq("rst_release", 32'(o_release), 32'h0);
        check_eq("rst_repeat",  32'(o_repeat),  32'h0);
        rst_n = 1'b1;
        step(4);

        // Clean press on ch0, held 20 cycles, then released
        drive(0, 1'b1);
        step(20);
        drive(0, 1'b0);
        step(10);

        // Bounce on ch1; the final 1 opens the stable run
        bounce = 6'b101101;
        for (int i = 5; i >= 0; i--) begin
            btn[1] = bounce[i];
            if (i == 0) drive(1, 1'b1);
            step(1);
        end
        step(19);
        drive(1, 1'b0);
        step(10);

        // Ch2: press, 3-cycle dip ignored, final fall lands release on a would-be repeat
        drive(2, 1'b1);
        step(8);
        btn[2] = 1'b0;
        step(3);
        btn[2] = 1'b1;
        step(5);
        drive(2, 1'b0);
        step(10);

        // Ch3 auto-repeat: held 30 cycles after the press strobe
        drive(3, 1'b1);
        step(LAT + 30);
        drive(3, 1'b0);
        step(10);

        // Ch0 (active-low pin) and ch1 (active-high pin) together
        drive(0, 1'b1);
        drive(1, 1'b1);
        step(LAT + 2);

        // Async reset mid-HOLD: outputs clear before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_level",   32'(o_level),   32'h0);
        check_eq("async_press",   32'(o_press),   32'h0);
        check_eq("async_release", 32'(o_release), 32'h0);
        check_eq("async_repeat",  32'(o_repeat),  32'h0);
        btn[1] = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        check_eq("inrst_level", 32'(o_level), 32'h0);
        check_eq("inrst_press", 32'(o_press), 32'h0);
        for (int ch = 0; ch < CH; ch++) begin
            pc[ch] = -1;
            rc[ch] = -1;
        end
        // Ch0 still held as reset lifts: one fresh press after the full latency
        rst_n = 1'b1;
        pc[0] = cyc + LAT;
        step(LAT + 6);
        drive(0, 1'b0);
        step(10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
